// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor.
// Rounds to nearest even, flushes subnormals to zero, and supports valid/ready backpressure.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         flag_invalid,
    output logic         flag_overflow
);
    localparam int SIG_W   = MAN_W + 1;
    localparam int ALN_W   = MAN_W + 4;
    localparam int SUM_W   = MAN_W + 5;
    localparam int RND_W   = MAN_W + 2;
    localparam int XE_W    = EXP_W + 2;
    localparam int LZ_W    = $clog2(ALN_W + 1);
    localparam int EXP_TOP = (1 << EXP_W) - 1;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF} spec_e;

    logic stall;

    logic             a_sign, b_sign, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_big;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic [SIG_W-1:0] a_sig, b_sig;

    logic             s1_valid_d, s1_valid_q, s1_invalid_d, s1_invalid_q;
    spec_e            s1_kind_d, s1_kind_q;
    logic             s1_sign_d, s1_sign_q, s1_zero_sign_d, s1_zero_sign_q;
    logic             s1_eff_sub_d, s1_eff_sub_q;
    logic [EXP_W-1:0] s1_exp_d, s1_exp_q, s1_diff_d, s1_diff_q;
    logic [SIG_W-1:0] s1_big_sig_d, s1_big_sig_q, s1_small_sig_d, s1_small_sig_q;

    logic             s2_valid_d, s2_valid_q, s2_invalid_d, s2_invalid_q;
    spec_e            s2_kind_d, s2_kind_q;
    logic             s2_sign_d, s2_sign_q, s2_zero_sign_d, s2_zero_sign_q;
    logic             s2_eff_sub_d, s2_eff_sub_q;
    logic [EXP_W-1:0] s2_exp_d, s2_exp_q;
    logic [ALN_W-1:0] s2_big_d, s2_big_q, s2_small_d, s2_small_q;
    logic [MAN_W+2:0] s2_ext, s2_shifted, s2_lost;

    logic             s3_valid_d, s3_valid_q, s3_invalid_d, s3_invalid_q;
    spec_e            s3_kind_d, s3_kind_q;
    logic             s3_sign_d, s3_sign_q, s3_zero_sign_d, s3_zero_sign_q;
    logic [EXP_W-1:0] s3_exp_d, s3_exp_q;
    logic [SUM_W-1:0] s3_sum_d, s3_sum_q;

    logic                   out_valid_d, out_valid_q;
    logic [W-1:0]           result_d, result_q;
    logic                   flag_invalid_d, flag_invalid_q, flag_overflow_d, flag_overflow_q;
    logic [LZ_W-1:0]        lzc;
    logic                   lz_found, round_up;
    logic [ALN_W-1:0]       norm;
    logic signed [XE_W-1:0] norm_exp, fin_exp;
    logic [RND_W-1:0]       rnd;
    logic [MAN_W-1:0]       fin_man;

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_invalid  = flag_invalid_q;
    assign flag_overflow = flag_overflow_q;

    assign a_sign = a[W-1];
    assign b_sign = b[W-1] ^ sub;
    assign a_exp  = a[W-2 -: EXP_W];
    assign b_exp  = b[W-2 -: EXP_W];
    assign a_man  = a[MAN_W-1:0];
    assign b_man  = b[MAN_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_nan  = (a_exp == EXP_MAX) && (a_man != '0);
    assign b_nan  = (b_exp == EXP_MAX) && (b_man != '0);
    assign a_inf  = (a_exp == EXP_MAX) && (a_man == '0);
    assign b_inf  = (b_exp == EXP_MAX) && (b_man == '0);
    assign a_sig  = a_zero ? '0 : {1'b1, a_man};
    assign b_sig  = b_zero ? '0 : {1'b1, b_man};
    // Subnormal mantissas are dropped so flushed operands compare as zero
    assign a_big  = {a_exp, (a_zero ? '0 : a_man)} >= {b_exp, (b_zero ? '0 : b_man)};

    always_comb begin
        s1_valid_d     = in_valid;
        s1_kind_d      = SP_NONE;
        s1_invalid_d   = 1'b0;
        s1_sign_d      = a_big ? a_sign : b_sign;
        s1_zero_sign_d = a_sign & b_sign;
        s1_eff_sub_d   = a_sign ^ b_sign;
        s1_exp_d       = a_big ? a_exp : b_exp;
        s1_diff_d      = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
        s1_big_sig_d   = a_big ? a_sig : b_sig;
        s1_small_sig_d = a_big ? b_sig : a_sig;
        if (a_nan || b_nan) begin
            s1_kind_d = SP_NAN;
        end else if (a_inf && b_inf && (a_sign != b_sign)) begin
            s1_kind_d    = SP_NAN;
            s1_invalid_d = 1'b1;
        end else if (a_inf) begin
            s1_kind_d = SP_INF;
            s1_sign_d = a_sign;
        end else if (b_inf) begin
            s1_kind_d = SP_INF;
            s1_sign_d = b_sign;
        end
    end

    always_comb begin
        s2_valid_d     = s1_valid_q;
        s2_kind_d      = s1_kind_q;
        s2_invalid_d   = s1_invalid_q;
        s2_sign_d      = s1_sign_q;
        s2_zero_sign_d = s1_zero_sign_q;
        s2_eff_sub_d   = s1_eff_sub_q;
        s2_exp_d       = s1_exp_q;
        s2_big_d       = {s1_big_sig_q, 3'b000};
        s2_ext         = {s1_small_sig_q, 2'b00};
        s2_shifted     = '0;
        s2_lost        = '0;
        // Bits shifted past the round position collapse into the sticky LSB
        if (int'(s1_diff_q) >= MAN_W + 3) begin
            s2_small_d = {{(ALN_W-1){1'b0}}, |s1_small_sig_q};
        end else begin
            s2_shifted = s2_ext >> s1_diff_q;
            s2_lost    = s2_ext & ~({(MAN_W+3){1'b1}} << s1_diff_q);
            s2_small_d = {s2_shifted, |s2_lost};
        end
    end

    always_comb begin
        s3_valid_d     = s2_valid_q;
        s3_kind_d      = s2_kind_q;
        s3_invalid_d   = s2_invalid_q;
        s3_sign_d      = s2_sign_q;
        s3_zero_sign_d = s2_zero_sign_q;
        s3_exp_d       = s2_exp_q;
        s3_sum_d       = s2_eff_sub_q ? ({1'b0, s2_big_q} - {1'b0, s2_small_q})
                                      : ({1'b0, s2_big_q} + {1'b0, s2_small_q});
    end

    always_comb begin
        lzc      = '0;
        lz_found = 1'b0;
        for (int i = ALN_W - 1; i >= 0; i--) begin
            if (!lz_found) begin
                if (s3_sum_q[i]) begin
                    lz_found = 1'b1;
                end else begin
                    lzc = lzc + LZ_W'(1);
                end
            end
        end
        if (s3_sum_q[SUM_W-1]) begin
            norm     = {s3_sum_q[SUM_W-1:2], s3_sum_q[1] | s3_sum_q[0]};
            norm_exp = XE_W'(s3_exp_q) + XE_W'(1);
        end else begin
            norm     = s3_sum_q[ALN_W-1:0] << lzc;
            norm_exp = XE_W'(s3_exp_q) - XE_W'(lzc);
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd      = {1'b0, norm[ALN_W-1:3]} + RND_W'(round_up);
        if (rnd[MAN_W+1]) begin
            fin_exp = norm_exp + XE_W'(1);
            fin_man = rnd[MAN_W:1];
        end else begin
            fin_exp = norm_exp;
            fin_man = rnd[MAN_W-1:0];
        end

        out_valid_d     = s3_valid_q;
        result_d        = '0;
        flag_invalid_d  = 1'b0;
        flag_overflow_d = 1'b0;
        if (s3_valid_q) begin
            case (s3_kind_q)
                SP_NAN: begin
                    result_d       = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
                    flag_invalid_d = s3_invalid_q;
                end
                SP_INF: result_d = {s3_sign_q, EXP_MAX, {MAN_W{1'b0}}};
                default: begin
                    if (s3_sum_q == '0) begin
                        result_d = {s3_zero_sign_q, {(W-1){1'b0}}};
                    end else if (int'(fin_exp) >= EXP_TOP) begin
                        result_d        = {s3_sign_q, EXP_MAX, {MAN_W{1'b0}}};
                        flag_overflow_d = 1'b1;
                    end else if (int'(fin_exp) <= 0) begin
                        result_d = {s3_sign_q, {(W-1){1'b0}}};
                    end else begin
                        result_d = {s3_sign_q, fin_exp[EXP_W-1:0], fin_man};
                    end
                end
            endcase
        end
    end

    // A stalled output freezes the whole pipe, so every register shares one enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q      <= 1'b0;
            s1_kind_q       <= SP_NONE;
            s1_invalid_q    <= 1'b0;
            s1_sign_q       <= 1'b0;
            s1_zero_sign_q  <= 1'b0;
            s1_eff_sub_q    <= 1'b0;
            s1_exp_q        <= '0;
            s1_diff_q       <= '0;
            s1_big_sig_q    <= '0;
            s1_small_sig_q  <= '0;
            s2_valid_q      <= 1'b0;
            s2_kind_q       <= SP_NONE;
            s2_invalid_q    <= 1'b0;
            s2_sign_q       <= 1'b0;
            s2_zero_sign_q  <= 1'b0;
            s2_eff_sub_q    <= 1'b0;
            s2_exp_q        <= '0;
            s2_big_q        <= '0;
            s2_small_q      <= '0;
            s3_valid_q      <= 1'b0;
            s3_kind_q       <= SP_NONE;
            s3_invalid_q    <= 1'b0;
            s3_sign_q       <= 1'b0;
            s3_zero_sign_q  <= 1'b0;
            s3_exp_q        <= '0;
            s3_sum_q        <= '0;
            out_valid_q     <= 1'b0;
            result_q        <= '0;
            flag_invalid_q  <= 1'b0;
            flag_overflow_q <= 1'b0;
        end else if (!stall) begin
            s1_valid_q      <= s1_valid_d;
            s1_kind_q       <= s1_kind_d;
            s1_invalid_q    <= s1_invalid_d;
            s1_sign_q       <= s1_sign_d;
            s1_zero_sign_q  <= s1_zero_sign_d;
            s1_eff_sub_q    <= s1_eff_sub_d;
            s1_exp_q        <= s1_exp_d;
            s1_diff_q       <= s1_diff_d;
            s1_big_sig_q    <= s1_big_sig_d;
            s1_small_sig_q  <= s1_small_sig_d;
            s2_valid_q      <= s2_valid_d;
            s2_kind_q       <= s2_kind_d;
            s2_invalid_q    <= s2_invalid_d;
            s2_sign_q       <= s2_sign_d;
            s2_zero_sign_q  <= s2_zero_sign_d;
            s2_eff_sub_q    <= s2_eff_sub_d;
            s2_exp_q        <= s2_exp_d;
            s2_big_q        <= s2_big_d;
            s2_small_q      <= s2_small_d;
            s3_valid_q      <= s3_valid_d;
            s3_kind_q       <= s3_kind_d;
            s3_invalid_q    <= s3_invalid_d;
            s3_sign_q       <= s3_sign_d;
            s3_zero_sign_q  <= s3_zero_sign_d;
            s3_exp_q        <= s3_exp_d;
            s3_sum_q        <= s3_sum_d;
            out_valid_q     <= out_valid_d;
            result_q        <= result_d;
            flag_invalid_q  <= flag_invalid_d;
            flag_overflow_q <= flag_overflow_d;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Testbench for fp_addsub_pipe: directed corner cases, randomized streaming with backpressure
// against an exact-arithmetic reference model, a stall scenario and reset with operations in flight.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_invalid;
    logic        flag_overflow;

    int total;
    int bad;

    fp_addsub_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_invalid(flag_invalid), .flag_overflow(flag_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Exact sum on a wide integer grid, then round-to-nearest-even with an unbounded exponent.
    // Returns {flag_invalid, flag_overflow, result}.
    function automatic logic [33:0] ref_model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic         xs, ys, rs;
        int           xe, ye, p, k, e;
        logic [299:0] mx, my, mag, rem, half;
        logic [24:0]  sig;
        xs = x[31];
        ys = y[31] ^ s;
        xe = int'(x[30:23]);
        ye = int'(y[30:23]);
        if ((xe == 255 && x[22:0] != 0) || (ye == 255 && y[22:0] != 0)) return {2'b00, 32'h7FC00000};
        if (xe == 255 && ye == 255 && xs != ys) return {2'b10, 32'h7FC00000};
        if (xe == 255) return {2'b00, xs, 8'hFF, 23'h0};
        if (ye == 255) return {2'b00, ys, 8'hFF, 23'h0};
        mx = (xe == 0) ? '0 : (300'({1'b1, x[22:0]}) << (xe - 1));
        my = (ye == 0) ? '0 : (300'({1'b1, y[22:0]}) << (ye - 1));
        if (xs == ys) begin
            mag = mx + my; rs = xs;
        end else if (mx >= my) begin
            mag = mx - my; rs = xs;
        end else begin
            mag = my - mx; rs = ys;
        end
        if (mag == 0) return {2'b00, xs & ys, 31'h0};
        p = 0;
        for (int i = 299; i >= 0; i--) begin
            if (mag[i]) begin
                p = i;
                break;
            end
        end
        if (p > 23) begin
            k    = p - 23;
            sig  = 25'(mag >> k);
            rem  = mag & ((300'(1) << k) - 300'(1));
            half = 300'(1) << (k - 1);
            if (rem > half || (rem == half && sig[0])) sig = sig + 25'(1);
        end else begin
            sig = 25'(mag << (23 - p));
        end
        e = p - 22;
        if (sig[24]) begin
            sig = sig >> 1;
            e++;
        end
        if (e >= 255) return {2'b01, rs, 8'hFF, 23'h0};
        if (e <= 0) return {2'b00, rs, 31'h0};
        return {2'b00, rs, 8'(e), sig[22:0]};
    endfunction

    function automatic logic [31:0] rand_operand(input logic [31:0] near);
        int sel;
        sel = int'($urandom_range(0, 11));
        case (sel)
            0: begin
                case ($urandom_range(0, 5))
                    0: return 32'h00000000;
                    1: return 32'h80000000;
                    2: return 32'h7F800000;
                    3: return 32'hFF800000;
                    4: return {1'b0, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
                    default: return {1'($urandom), 8'h00, 23'($urandom)};
                endcase
            end
            1: return {1'($urandom), 8'hFE, 23'($urandom)};
            2: return near;
            3, 4, 5, 6, 7: return {1'($urandom), 8'(int'(near[30:23]) + int'($urandom_range(0, 6)) - 3), 23'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic run_single(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                              output logic [31:0] r, output logic fi, output logic fo, output int lat);
        @(negedge clk);
        a = xa; b = xb; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = result; fi = flag_invalid; fo = flag_overflow;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++;
        if (result !== 32'h0) begin bad++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
        total++;
        if ({flag_invalid, flag_overflow} !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_flags: got %b%b expected 00", flag_invalid, flag_overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] va[14] = '{32'h3F800000, 32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800000,
                                32'h7F800000, 32'h7F7FFFFF, 32'h80000000, 32'h00000000, 32'h7FC12345,
                                32'hFF800000, 32'h00400000, 32'h00800000, 32'h00C00000};
        logic [31:0] vb[14] = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h33800000, 32'h33800001,
                                32'h7F800000, 32'h7F7FFFFF, 32'h80000000, 32'h80000000, 32'h3F800000,
                                32'h3F800000, 32'h00000000, 32'h00400000, 32'h00800000};
        logic        vs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] vr[14] = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800001,
                                32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h00000000, 32'h7FC00000,
                                32'hFF800000, 32'h00000000, 32'h00800000, 32'h00000000};
        logic [1:0]  vf[14] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00,
                                2'b00, 2'b00, 2'b00, 2'b00};
        logic [31:0] r;
        logic        fi, fo;
        int          lat;
        for (int i = 0; i < 14; i++) begin
            run_single(va[i], vb[i], vs[i], r, fi, fo, lat);
            total++;
            if (lat !== 4) begin bad++; $display("[TB] FAIL dir%0d_latency: got %0d expected 4", i, lat); end
            total++;
            if (r !== vr[i]) begin bad++; $display("[TB] FAIL dir%0d_result: got %h expected %h", i, r, vr[i]); end
            total++;
            if ({fi, fo} !== vf[i]) begin bad++; $display("[TB] FAIL dir%0d_flags: got %b%b expected %b", i, fi, fo, vf[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [33:0] sb[$];
        logic [33:0] expv;
        int          sent;
        sent = 0;
        for (int cyc = 0; cyc < 6000 && (sent < 400 || sb.size() != 0); cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 400) && ($urandom_range(0, 4) != 0);
            a   = rand_operand($urandom);
            b   = rand_operand(a);
            sub = 1'($urandom);
            #1;
            total++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                bad++; $display("[TB] FAIL rnd_in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready));
            end
            if (!out_valid) begin
                total++;
                if ({flag_invalid, flag_overflow} !== 2'b00) begin
                    bad++; $display("[TB] FAIL rnd_idle_flags: got %b%b expected 00", flag_invalid, flag_overflow);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("[TB] FAIL rnd_extra_output: got result %h expected none", result);
                end else begin
                    expv = sb.pop_front();
                    if ({flag_invalid, flag_overflow, result} !== expv) begin
                        bad++;
                        $display("[TB] FAIL rnd_result: got %b%b_%h expected %b_%h",
                                 flag_invalid, flag_overflow, result, expv[33:32], expv[31:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(ref_model(a, b, sub));
                sent++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++;
        if (sent != 400 || sb.size() != 0) begin
            bad++; $display("[TB] FAIL rnd_drain: got sent=%0d pending=%0d expected 400/0", sent, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va[8], vb[8];
        logic        vs[8];
        logic [33:0] expv[8];
        int          sent, got;
        for (int i = 0; i < 8; i++) begin
            va[i] = rand_operand($urandom);
            vb[i] = rand_operand(va[i]);
            vs[i] = 1'($urandom);
            expv[i] = ref_model(va[i], vb[i], vs[i]);
        end
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 9);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                a = va[sent]; b = vb[sent]; sub = vs[sent];
            end
            #1;
            if (cyc < 12) begin
                total++;
                if (in_ready !== !(cyc >= 6 && cyc <= 9)) begin
                    bad++; $display("[TB] FAIL b2b_in_ready_c%0d: got %b expected %b", cyc, in_ready, !(cyc >= 6 && cyc <= 9));
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if ({flag_invalid, flag_overflow, result} !== expv[got]) begin
                    bad++;
                    $display("[TB] FAIL b2b_result%0d: got %b%b_%h expected %b_%h", got,
                             flag_invalid, flag_overflow, result, expv[got][33:32], expv[got][31:0]);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++;
        if (got != 8) begin bad++; $display("[TB] FAIL b2b_count: got %0d expected 8", got); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_duplicate: got out_valid %b expected 0", out_valid); end
        end
    endtask

    task automatic test_reset_in_flight();
        logic [31:0] r;
        logic        fi, fo;
        int          lat;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000 + 32'(i); sub = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1 || result !== 32'h40000000) begin
            bad++; $display("[TB] FAIL rif_pre_output: got %b/%h expected 1/40000000", out_valid, result);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rif_out_valid: got %b expected 0", out_valid); end
        total++;
        if (result !== 32'h0) begin bad++; $display("[TB] FAIL rif_result: got %h expected 00000000", result); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rif_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rif_stale_c%0d: got out_valid %b expected 0", i, out_valid); end
        end
        run_single(32'h3F800000, 32'h40000000, 1'b0, r, fi, fo, lat);
        total++;
        if (lat !== 4) begin bad++; $display("[TB] FAIL rif_first_latency: got %0d expected 4", lat); end
        total++;
        if (r !== 32'h40400000) begin bad++; $display("[TB] FAIL rif_first_result: got %h expected 40400000", r); end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored mantissa field width; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operands present on a, b, sub.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  W  IEEE-754-style operand A {sign, exp, man}.
REQ-008 b  input  W  operand B, same format.
REQ-009 sub  input  1  1: compute a-b; 0: compute a+b.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 result  output  W  packed sum/difference.
REQ-013 flag_invalid  output  1  NaN produced from non-NaN inputs (inf-inf).
REQ-014 flag_overflow  output  1  finite inputs rounded to infinity.

Function
REQ-015 Four-stage pipeline S1 unpack/classify/swap, S2 align, S3 add/sub, S4 normalise/round/pack; latency exactly 4 cycles from accepted input to out_valid absent stall.
REQ-016 Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 stall = out_valid && !out_ready; in_ready = !stall; during stall every stage register, valid bit and output holds.
REQ-018 Bubbles propagate: per-stage valid bit; stage data with valid=0 never reaches outputs; throughput one operation per cycle with out_ready high.
REQ-019 Effective B sign = b.sign XOR sub; effective operation is subtract when signs differ.
REQ-020 S1 orders operands by magnitude {exp,man}; larger becomes big; result sign = big sign, except exact cancellation.
REQ-021 Hidden bit = 1 for exp != 0; exp == 0 inputs (zero and subnormal) treated as signed zero (flush-to-zero).
REQ-022 S2 right-shifts small significand by exp difference into MAN_W+1 bits plus guard, round, sticky; all shifted-out bits OR into sticky; difference >= MAN_W+3 leaves only sticky (nonzero small operand).
REQ-023 S3 adder width MAN_W+5 bits; subtraction big-small never negative.
REQ-024 S4: carry-out -> shift right 1, exp+1, LSB into sticky; else leading-zero count, shift left, exp minus count.
REQ-025 Rounding round-to-nearest-even on guard/round/sticky; mantissa overflow from rounding -> exp+1.
REQ-026 Normalised exp >= 2^EXP_W-1 -> +/-infinity, flag_overflow=1.
REQ-027 Normalised exp <= 0 -> signed zero (flush-to-zero), no flag.
REQ-028 Exact cancellation (x - x) -> +0; (-0)+(-0) -> -0; (+0)+(-0) -> +0.
REQ-029 Any NaN input -> canonical quiet NaN: sign 0, exp all ones, mantissa MSB 1, rest 0; flags 0.
REQ-030 inf + (-inf) effective -> canonical NaN, flag_invalid=1; inf with finite -> that inf, flags 0.
REQ-031 Flags valid only when out_valid=1; 0 otherwise.

Reset
REQ-032 rst_n low asynchronously clears all stage valid bits, out_valid, result, flag_invalid, flag_overflow to 0.
REQ-033 Operations in flight at reset are discarded; in_ready=1 after reset release.
REQ-034 First accepted operation after reset release yields out_valid exactly 4 cycles later.

Verification (default parameters)
REQ-035 a=0x3F800000, b=0x3F800000, sub=0 -> result 0x40000000 after 4 cycles, flags 0.
REQ-036 a=0x3F800000, b=0x3F800000, sub=1 -> 0x00000000; a=0x40400000, b=0xBF800000, sub=0 -> 0x40000000.
REQ-037 a=0x3F800000, b=0x33800000 (2^-24 tie), sub=0 -> 0x3F800000 (round to even); b=0x33800001 -> 0x3F800001.
REQ-038 a=0x7F800000, b=0x7F800000, sub=1 -> 0x7FC00000, flag_invalid=1; a=0x7F7FFFFF, b=0x7F7FFFFF -> 0x7F800000, flag_overflow=1.
REQ-039 Stream 8 back-to-back ops, out_ready low cycles 6-9 -> in_ready low same cycles, no result lost/duplicated, order preserved.
REQ-040 Assert rst_n low with 3 ops in flight -> out_valid 0 immediately, no stale result after release.
